sd_word_packer: RTL and testbench
=================================

SD_WORD_PACKER -- requirements
Module: sd_word_packer

Interface
REQ-001 SHALL have parameter NWORDS, default 128, the number of 32-bit words per block (a 512-byte SD sector).
REQ-002 SHALL have parameter LITTLE_END, default 1, where 1 means the first byte received goes to bits [7:0] and 0 means it goes to bits [31:24].
REQ-003 SHALL have port iCLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port iStart, input, 1 bit: arms capture of a new block.
REQ-006 SHALL have port iByteValid, input, 1 bit: iByte is valid this cycle (one-cycle strobe from the SD SPI controller).
REQ-007 SHALL have port iByte, input, 8 bits: received data byte.
REQ-008 SHALL have port oWrEn, output, 1 bit: write strobe to the sector buffer.
REQ-009 SHALL have port oWrAddr, output, 7 bits: buffer word address.
REQ-010 SHALL have port oWrData, output, 32 bits: packed word.
REQ-011 SHALL have port oBusy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-012 SHALL have port oDone, output, 1 bit: one-cycle pulse at block completion.
REQ-013 SHALL have port oCrcErr, output, 1 bit: sticky CRC mismatch flag.
REQ-014 SHALL have port oWordCount, output, 8 bits: number of words written in the current block (0..128).

Function
REQ-015 SHALL implement the FSM states IDLE, DATA, CRC and DONE.
REQ-016 IDLE -> DATA on iStart; on entry, the byte lane counter, oWordCount and oWrAddr are cleared to 0 and oCrcErr is cleared to 0.
REQ-017 In IDLE and DONE, iByteValid SHALL be ignored.
REQ-018 In DATA, each iByteValid SHALL shift iByte into the lane selected by the lane counter (0..3) per LITTLE_END, then increment the lane counter modulo 4.
REQ-019 On the fourth byte of a word, oWrEn SHALL be high on the next cycle for exactly one cycle, with oWrData equal to the completed word and oWrAddr equal to the current word index.
REQ-020 oWrAddr and oWordCount SHALL increment in the cycle after the oWrEn pulse; oWrAddr wraps from 127 to 0 and oWordCount saturates at NWORDS.
REQ-021 Back-to-back iByteValid strobes on consecutive cycles SHALL be accepted without loss.
REQ-022 After word NWORDS-1 is written: DATA -> CRC when the CRC feature is compiled in, otherwise DATA -> DONE.
REQ-023 In CRC, exactly 2 bytes SHALL be accepted (MSB first) and compared with the computed CRC-16 (details in Configuration), then CRC -> DONE.
REQ-024 DONE SHALL assert oDone for one cycle and SHALL return to IDLE on the next cycle.
REQ-025 iStart asserted in DATA or CRC SHALL abort the current block and restart as on IDLE entry, with no oDone; any partial word SHALL be discarded.
REQ-026 iStart in the same cycle as iByteValid SHALL take priority, and that byte SHALL be discarded.
REQ-027 iStart in DONE SHALL be honoured on the following IDLE cycle; the oDone pulse is never suppressed.

Reset
REQ-028 Reset SHALL force the FSM to IDLE and drive oWrEn=0, oWrAddr=0, oWrData=0, oBusy=0, oDone=0, oCrcErr=0, oWordCount=0, lane counter=0 and CRC register=0.
REQ-029 Reset SHALL take priority over all other inputs, including mid-block, where it discards any pending write.

Configuration
REQ-030 With macro SD_PACKER_CRC16_EN defined, the block SHALL compute CRC-16-CCITT (polynomial 0x1021, init 0x0000, MSB first) over the 512 data bytes.
REQ-031 With SD_PACKER_CRC16_EN defined, the CRC state SHALL be used, and oCrcErr SHALL be set on mismatch and held until the next iStart or Reset.
REQ-032 Without SD_PACKER_CRC16_EN, the CRC state and logic SHALL be absent, DATA SHALL go straight to DONE, and oCrcErr SHALL be tied to 0.

Verification
REQ-033 Reset, then iStart, then 512 bytes 0x00..0xFF repeated, LITTLE_END=1 -> first write addr 0 data 0x03020100, last write addr 127 data 0xFFFEFDFC, oWordCount=128, one oDone.
REQ-034 LITTLE_END=0, bytes 0xDE 0xAD 0xBE 0xEF -> oWrEn one cycle later with data 0xDEADBEEF, addr 0.
REQ-035 CRC enabled: 512 bytes of 0xFF followed by CRC bytes 0x7F 0xA1 -> oCrcErr=0; repeat with 0x7F 0xA0 -> oCrcErr=1, held until the next iStart.
REQ-036 After 6 bytes, assert iStart together with a byte -> no oDone, oWordCount=0, next word written to addr 0 contains only bytes sent after iStart.
REQ-037 Assert Reset after 300 bytes -> all outputs 0 on the next cycle; iByteValid is then ignored until iStart.
REQ-038 Hold iByteValid high for 512 consecutive cycles -> 128 writes, every oWrEn pulse exactly 4 cycles apart, no bytes lost.

Source files
------------

// File: rtl/sd_word_packer.sv
// sd_word_packer
// Packs the byte stream of one SD data block (NWORDS x 32-bit words) into
// words and emits one write strobe per completed word to a sector buffer.
//
// Optional feature: define SD_PACKER_CRC16_EN to receive and check the
// trailing CRC-16-CCITT (poly 0x1021, init 0, MSB first) of the data bytes.
// Without it the block goes straight from DATA to DONE and oCrcErr is 0.
//
// Ports
//   iCLK        clock, rising edge
//   Reset       synchronous active-high reset
//   iStart      arm (or abort and re-arm) capture of a block
//   iByteValid  one-cycle strobe qualifying iByte
//   iByte       received data byte
//   oWrEn       one-cycle write strobe, the cycle after a word's 4th byte
//   oWrAddr     word address of the write (wraps 127 -> 0)
//   oWrData     packed word (LITTLE_END selects lane order)
//   oBusy       FSM not in IDLE
//   oDone       one-cycle pulse at block completion
//   oCrcErr     sticky CRC mismatch flag (cleared by iStart / Reset)
//   oWordCount  words written in the current block, saturates at NWORDS
module sd_word_packer #(
  parameter int NWORDS     = 128,
  parameter int LITTLE_END = 1
) (
  input  logic        iCLK,
  input  logic        Reset,
  input  logic        iStart,
  input  logic        iByteValid,
  input  logic [7:0]  iByte,
  output logic        oWrEn,
  output logic [6:0]  oWrAddr,
  output logic [31:0] oWrData,
  output logic        oBusy,
  output logic        oDone,
  output logic        oCrcErr,
  output logic [7:0]  oWordCount
);

  typedef enum logic [1:0] {IDLE, DATA, CRC, DONE} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  lane_reg;
  logic [1:0]  lane_sel;
  logic [31:0] word_reg;
  logic [31:0] word_merged;
  logic        wr_en_reg;
  logic [31:0] wr_data_reg;
  logic [6:0]  wr_addr_reg;
  logic [7:0]  word_count_reg;
  logic        start_pending_reg;
  logic        restart;
  logic        data_accept;

  // Physical lane written by the current byte; big-endian fills from the top.
  assign lane_sel = (LITTLE_END != 0) ? lane_reg : (2'd3 - lane_reg);

  // Word as it looks once the current byte is merged in.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign word_merged[gi*8 +: 8] = (lane_sel == 2'(gi)) ? iByte : word_reg[gi*8 +: 8];
    end
  endgenerate

`ifdef SD_PACKER_CRC16_EN
  logic [15:0] crc_reg;
  logic [7:0]  crc_hi_reg;
  logic        crc_phase_reg;
  logic        crc_err_reg;
  logic        crc_accept;
  logic        last_word_byte;

  // Leave DATA on the final data byte itself, so CRC bytes may follow
  // back-to-back while the last word's write is still in flight.
  assign last_word_byte = (lane_reg == 2'd3) && (word_count_reg == 8'(NWORDS - 1));

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
    end
    return c;
  endfunction
`else
  logic last_written;

  // The write of the final word is on the outputs this cycle.
  assign last_written = wr_en_reg && (word_count_reg == 8'(NWORDS - 1));
`endif

  always_ff @(posedge iCLK) begin
    if (Reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    restart     = 1'b0;
    data_accept = 1'b0;
`ifdef SD_PACKER_CRC16_EN
    crc_accept  = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (iStart || start_pending_reg) begin
          restart    = 1'b1;
          state_next = DATA;
        end
      end
      DATA: begin
        if (iStart) begin
          restart = 1'b1;
        end else begin
`ifdef SD_PACKER_CRC16_EN
          if (iByteValid) begin
            data_accept = 1'b1;
            if (last_word_byte) state_next = CRC;
          end
`else
          // Bytes arriving while the last word is being written are ignored.
          if (last_written) begin
            state_next = DONE;
          end else if (iByteValid) begin
            data_accept = 1'b1;
          end
`endif
        end
      end
      CRC: begin
`ifdef SD_PACKER_CRC16_EN
        if (iStart) begin
          restart    = 1'b1;
          state_next = DATA;
        end else if (iByteValid) begin
          crc_accept = 1'b1;
          if (crc_phase_reg) state_next = DONE;
        end
`else
        state_next = IDLE;
`endif
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (Reset) begin
      lane_reg          <= 2'd0;
      word_reg          <= 32'd0;
      wr_en_reg         <= 1'b0;
      wr_data_reg       <= 32'd0;
      wr_addr_reg       <= 7'd0;
      word_count_reg    <= 8'd0;
      start_pending_reg <= 1'b0;
    end else begin
      wr_en_reg <= data_accept && (lane_reg == 2'd3);
      if (data_accept && (lane_reg == 2'd3)) begin
        wr_data_reg <= word_merged;
      end
      // iStart seen during DONE is replayed from the following IDLE cycle.
      start_pending_reg <= (state_reg == DONE) && iStart;
      if (restart) begin
        lane_reg       <= 2'd0;
        word_reg       <= 32'd0;
        wr_addr_reg    <= 7'd0;
        word_count_reg <= 8'd0;
      end else begin
        if (data_accept) begin
          lane_reg <= lane_reg + 2'd1;
          word_reg <= word_merged;
        end
        if (wr_en_reg) begin
          wr_addr_reg <= wr_addr_reg + 7'd1;
          if (word_count_reg != 8'(NWORDS)) begin
            word_count_reg <= word_count_reg + 8'd1;
          end
        end
      end
    end
  end

`ifdef SD_PACKER_CRC16_EN
  always_ff @(posedge iCLK) begin
    if (Reset) begin
      crc_reg       <= 16'd0;
      crc_hi_reg    <= 8'd0;
      crc_phase_reg <= 1'b0;
      crc_err_reg   <= 1'b0;
    end else if (restart) begin
      crc_reg       <= 16'd0;
      crc_hi_reg    <= 8'd0;
      crc_phase_reg <= 1'b0;
      crc_err_reg   <= 1'b0;
    end else begin
      if (data_accept) begin
        crc_reg <= crc16_byte(crc_reg, iByte);
      end
      if (crc_accept) begin
        if (!crc_phase_reg) begin
          crc_hi_reg    <= iByte;
          crc_phase_reg <= 1'b1;
        end else begin
          crc_phase_reg <= 1'b0;
          if ({crc_hi_reg, iByte} != crc_reg) crc_err_reg <= 1'b1;
        end
      end
    end
  end

  assign oCrcErr = crc_err_reg;
`else
  assign oCrcErr = 1'b0;
`endif

  assign oWrEn      = wr_en_reg;
  assign oWrAddr    = wr_addr_reg;
  assign oWrData    = wr_data_reg;
  assign oWordCount = word_count_reg;
  assign oBusy      = (state_reg != IDLE);
  assign oDone      = (state_reg == DONE);

endmodule

// File: tb/tb_sd_word_packer.sv
// Testbench for sd_word_packer: two instances (little- and big-endian) share
// the stimulus; writes are collected by a monitor and compared with words
// packed directly from the list of data bytes sent since the last iStart.
// Define SD_PACKER_CRC16_EN to also exercise the trailing CRC bytes.
module tb_sd_word_packer;

  logic        iCLK = 1'b0;
  logic        Reset, iStart, iByteValid;
  logic [7:0]  iByte;

  logic        le_wr_en, be_wr_en, le_busy, be_busy, le_done, be_done, le_crc_err, be_crc_err;
  logic [6:0]  le_wr_addr, be_wr_addr;
  logic [31:0] le_wr_data, be_wr_data;
  logic [7:0]  le_word_count, be_word_count;

  sd_word_packer #(.NWORDS(128), .LITTLE_END(1)) u_le (
    .iCLK(iCLK), .Reset(Reset), .iStart(iStart), .iByteValid(iByteValid), .iByte(iByte),
    .oWrEn(le_wr_en), .oWrAddr(le_wr_addr), .oWrData(le_wr_data), .oBusy(le_busy),
    .oDone(le_done), .oCrcErr(le_crc_err), .oWordCount(le_word_count)
  );

  sd_word_packer #(.NWORDS(128), .LITTLE_END(0)) u_be (
    .iCLK(iCLK), .Reset(Reset), .iStart(iStart), .iByteValid(iByteValid), .iByte(iByte),
    .oWrEn(be_wr_en), .oWrAddr(be_wr_addr), .oWrData(be_wr_data), .oBusy(be_busy),
    .oDone(be_done), .oCrcErr(be_crc_err), .oWordCount(be_word_count)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [6:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         done_le = 0;
  int         done_be = 0;
  wr_t        wq_le[$];
  wr_t        wq_be[$];
  logic [7:0] sent[$];

  always @(posedge iCLK) cyc <= cyc + 1;

  always @(negedge iCLK) begin
    if (le_wr_en) wq_le.push_back('{addr: le_wr_addr, data: le_wr_data, cyc: cyc});
    if (be_wr_en) wq_be.push_back('{addr: be_wr_addr, data: be_wr_data, cyc: cyc});
    if (le_done) done_le <= done_le + 1;
    if (be_done) done_be <= done_be + 1;
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Data byte: recorded in the reference byte list.
  task automatic send(input logic [7:0] b);
    iByteValid = 1'b1;
    iByte      = b;
    sent.push_back(b);
    tick();
    iByteValid = 1'b0;
  endtask

  // Byte that is not block data (CRC bytes, ignored bytes).
  task automatic send_raw(input logic [7:0] b);
    iByteValid = 1'b1;
    iByte      = b;
    tick();
    iByteValid = 1'b0;
  endtask

  task automatic clear_model();
    sent.delete();
    wq_le.delete();
    wq_be.delete();
  endtask

  task automatic start_block();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    clear_model();
  endtask

  // Word k of the block as the byte-order rules define it.
  function automatic logic [31:0] exp_word(input bit le, input int k);
    logic [31:0] w;
    w = 32'd0;
    for (int j = 0; j < 4; j++) begin
      if (le) w[8*j +: 8] = sent[4*k + j];
      else    w[31 - 8*j -: 8] = sent[4*k + j];
    end
    return w;
  endfunction

  task automatic check_writes(input string tag);
    int nexp;
    nexp = sent.size() / 4;
    if (nexp > 128) nexp = 128;
    chk({tag, "_nwr_le"}, wq_le.size(), nexp);
    chk({tag, "_nwr_be"}, wq_be.size(), nexp);
    for (int i = 0; i < nexp && i < wq_le.size(); i++) begin
      chk($sformatf("%s_addr_le%0d", tag, i), wq_le[i].addr, i % 128);
      chk($sformatf("%s_data_le%0d", tag, i), wq_le[i].data, exp_word(1'b1, i));
    end
    for (int i = 0; i < nexp && i < wq_be.size(); i++) begin
      chk($sformatf("%s_data_be%0d", tag, i), wq_be[i].data, exp_word(1'b0, i));
    end
    $display("block %s: bytes=%0d writes_le=%0d writes_be=%0d", tag, sent.size(), wq_le.size(), wq_be.size());
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (le_done !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, le_done, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wren"},  {le_wr_en, be_wr_en}, 2'b00);
    chk({tag, "_addr"},  {le_wr_addr, be_wr_addr}, 14'd0);
    chk({tag, "_data"},  {le_wr_data, be_wr_data}, 64'd0);
    chk({tag, "_busy"},  {le_busy, be_busy}, 2'b00);
    chk({tag, "_done"},  {le_done, be_done}, 2'b00);
    chk({tag, "_crc"},   {le_crc_err, be_crc_err}, 2'b00);
    chk({tag, "_count"}, {le_word_count, be_word_count}, 16'd0);
  endtask

`ifdef SD_PACKER_CRC16_EN
  function automatic logic [15:0] crc_of_sent();
    logic [15:0] c;
    c = 16'd0;
    foreach (sent[i]) begin
      for (int b = 7; b >= 0; b--) begin
        if (c[15] ^ sent[i][b]) c = {c[14:0], 1'b0} ^ 16'h1021;
        else                    c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

  task automatic send_crc();
    logic [15:0] c;
    c = crc_of_sent();
    send_raw(c[15:8]);
    send_raw(c[7:0]);
  endtask
`endif

  initial begin
    Reset      = 1'b1;
    iStart     = 1'b0;
    iByteValid = 1'b0;
    iByte      = 8'd0;
    gap(3);
    check_all_zero("reset");
    Reset = 1'b0;
    tick();

    // Bytes in IDLE are ignored.
    for (int i = 0; i < 3; i++) send_raw(8'($urandom));
    gap(3);
    chk("idle_nwr", wq_le.size(), 0);
    chk("idle_busy", le_busy, 1'b0);
    chk("idle_count", le_word_count, 8'd0);

    // Block A: 0x00..0xFF repeated, random gaps between bytes.
    start_block();
    chk("A_busy", {le_busy, be_busy}, 2'b11);
    for (int i = 0; i < 512; i++) begin
      send(8'(i));
      if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 2));
    end
`ifdef SD_PACKER_CRC16_EN
    send_crc();
`endif
    wait_done("A");
    check_writes("A");
    if (wq_le.size() == 128) begin
      chk("A_first_data", wq_le[0].data, 32'h03020100);
      chk("A_last_addr", wq_le[127].addr, 7'd127);
      chk("A_last_data", wq_le[127].data, 32'hFFFEFDFC);
    end
    chk("A_count", le_word_count, 8'd128);
    chk("A_crc_err", le_crc_err, 1'b0);
    // iStart during DONE: pulse still completes, capture starts after IDLE.
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    chk("A_done_one_cycle", le_done, 1'b0);
    chk("A_idle_after_done", le_busy, 1'b0);
    chk("A_done_count", done_le, 1);
    tick();
    chk("A_start_in_done", le_busy, 1'b1);
    chk("A_count_cleared", le_word_count, 8'd0);
    clear_model();

    // Block B: 512 random bytes on consecutive cycles.
    for (int i = 0; i < 512; i++) send(8'($urandom));
`ifdef SD_PACKER_CRC16_EN
    send_crc();
`endif
    wait_done("B");
    check_writes("B");
    for (int i = 1; i < wq_le.size(); i++) begin
      chk($sformatf("B_spacing%0d", i), wq_le[i].cyc - wq_le[i-1].cyc, 4);
    end
    tick();
    chk("B_done_count", done_le, 2);

    // Block C: abort after 6 bytes with iStart plus a byte.
    gap(2);
    start_block();
    for (int i = 0; i < 6; i++) send(8'($urandom));
    chk("C_pre_abort_nwr", wq_le.size(), 1);
    iStart     = 1'b1;
    iByteValid = 1'b1;
    iByte      = 8'hAA;
    tick();
    iStart     = 1'b0;
    iByteValid = 1'b0;
    clear_model();
    chk("C_count_after_abort", le_word_count, 8'd0);
    chk("C_busy_after_abort", le_busy, 1'b1);
    for (int i = 0; i < 4; i++) send(8'($urandom));
    tick();
    check_writes("C");
    chk("C_no_done", done_le, 2);

    // Block D: lane order check with DE AD BE EF.
    start_block();
    send(8'hDE);
    send(8'hAD);
    send(8'hBE);
    send(8'hEF);
    chk("D_be_wren", be_wr_en, 1'b1);
    chk("D_be_data", be_wr_data, 32'hDEADBEEF);
    chk("D_be_addr", be_wr_addr, 7'd0);
    chk("D_le_data", le_wr_data, 32'hEFBEADDE);
    tick();
    chk("D_be_wren_one_cycle", be_wr_en, 1'b0);
    chk("D_be_addr_inc", be_wr_addr, 7'd1);
    chk("D_be_count", be_word_count, 8'd1);
    $display("block D: bytes=4 data_be=%08h", wq_be.size() > 0 ? wq_be[0].data : 32'd0);

    // Block E: reset after 300 bytes, then bytes without iStart are ignored.
    start_block();
    for (int i = 0; i < 300; i++) send(8'($urandom));
    Reset      = 1'b1;
    iByteValid = 1'b1;
    iByte      = 8'h55;
    tick();
    Reset      = 1'b0;
    iByteValid = 1'b0;
    check_all_zero("E_reset");
    clear_model();
    for (int i = 0; i < 8; i++) send_raw(8'($urandom));
    gap(3);
    chk("E_ignored_nwr", wq_le.size(), 0);
    chk("E_ignored_count", le_word_count, 8'd0);
    chk("E_ignored_busy", le_busy, 1'b0);
    $display("block E: reset after 300 bytes");

`ifdef SD_PACKER_CRC16_EN
    // Block F: known CRC of 512 x 0xFF is 0x7FA1.
    start_block();
    for (int i = 0; i < 512; i++) send(8'hFF);
    send_raw(8'h7F);
    send_raw(8'hA1);
    wait_done("F_good");
    chk("F_good_crc_err", le_crc_err, 1'b0);
    gap(2);
    start_block();
    for (int i = 0; i < 512; i++) send(8'hFF);
    send_raw(8'h7F);
    send_raw(8'hA0);
    wait_done("F_bad");
    chk("F_bad_crc_err", le_crc_err, 1'b1);
    gap(4);
    chk("F_bad_crc_held", le_crc_err, 1'b1);
    start_block();
    chk("F_crc_cleared", le_crc_err, 1'b0);
    $display("block F: crc good/bad");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
